instr_fetch_stage: RTL and testbench

Downstream neighbour of the micro-unit program counter.
- Takes the PC's 2-bit address, reads a small writable instruction store and holds the word in an instruction register.
- Presents the word to the decoder with a valid/ready handshake.
- Returns a one-cycle End pulse to the program counter so the PC advances only after the decoder has consumed the word.

---
 rtl/instr_fetch_stage.sv | 124 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: latches the PC address, reads a small writable store into an
// instruction register, hands it to the decoder and pulses End. Optional macro: INSTR_PARITY_CHECK_EN.
module instr_fetch_stage #(
  parameter int ADDR_W  = 2,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic               AddrValid,
  input  logic               WrEn,
  input  logic [ADDR_W-1:0]  WrAddr,
  input  logic [INSTR_W-1:0] WrData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic               End,
  output logic               Busy,
  output logic [7:0]         FetchCount,
`ifdef INSTR_PARITY_CHECK_EN
  output logic               ParErr,
`endif
  output logic [1:0]         DbgState
);

  // Decoder handshake: a word transfers on a rising edge where InstrValid and InstrReady
  // are both high; InstrValid stays high and Instr stays stable until that edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_VALID = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q;
  logic                end_q;
  logic                busy_q;
  logic [7:0]          fetch_cnt_q;
  logic [7:0]          fetch_cnt_d;
  logic [INSTR_W-1:0]  mem_q [DEPTH];
`ifdef INSTR_PARITY_CHECK_EN
  logic                par_q [DEPTH];
  logic                par_err_q;
`endif

  assign fetch_cnt_d = (fetch_cnt_q == 8'hFF) ? fetch_cnt_q : fetch_cnt_q + 8'd1;

  // Store write and FSM share one process; nonblocking reads in READ see the pre-write word.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      end_q         <= 1'b0;
      busy_q        <= 1'b0;
      fetch_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef INSTR_PARITY_CHECK_EN
        par_q[i] <= 1'b0;
`endif
      end
`ifdef INSTR_PARITY_CHECK_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      if (WrEn) begin
        mem_q[WrAddr] <= WrData;
`ifdef INSTR_PARITY_CHECK_EN
        par_q[WrAddr] <= ^WrData;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (AddrValid) begin
            addr_q  <= Addr;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          instr_q       <= mem_q[addr_q];
          instr_valid_q <= 1'b1;
          state_q       <= S_VALID;
`ifdef INSTR_PARITY_CHECK_EN
          if ((^mem_q[addr_q]) != par_q[addr_q]) par_err_q <= 1'b1;
`endif
        end
        S_VALID: begin
          if (InstrReady) begin
            instr_valid_q <= 1'b0;
            end_q         <= 1'b1;
            fetch_cnt_q   <= fetch_cnt_d;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          end_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign End        = end_q;
  assign Busy       = busy_q;
  assign FetchCount = fetch_cnt_q;
  assign DbgState   = state_q;
`ifdef INSTR_PARITY_CHECK_EN
  assign ParErr     = par_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: reset, basic fetch, back-pressure, read/write
// collision, PC-driven sequence and FetchCount saturation.
module tb_instr_fetch_stage;

  logic       Clock;
  logic       Reset_n;
  logic [1:0] Addr;
  logic       AddrValid;
  logic       WrEn;
  logic [1:0] WrAddr;
  logic [7:0] WrData;
  logic [7:0] Instr;
  logic       InstrValid;
  logic       InstrReady;
  logic       End;
  logic       Busy;
  logic [7:0] FetchCount;
  logic [1:0] DbgState;
`ifdef INSTR_PARITY_CHECK_EN
  logic       ParErr;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_stage dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Addr       (Addr),
    .AddrValid  (AddrValid),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .End        (End),
    .Busy       (Busy),
    .FetchCount (FetchCount),
`ifdef INSTR_PARITY_CHECK_EN
    .ParErr     (ParErr),
`endif
    .DbgState   (DbgState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    step();
    WrEn = 1'b0;
  endtask

  logic [7:0] seq_exp [4];
  int ends;
  int words;
  logic prev_end;

  initial begin
    Reset_n = 1'b0; Addr = '0; AddrValid = 1'b0; WrEn = 1'b0;
    WrAddr = '0; WrData = '0; InstrReady = 1'b0;
    #12;
    chk("rst_instr", Instr, 8'h00);
    chk("rst_valid", InstrValid, 1'b0);
    chk("rst_end", End, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_count", FetchCount, 8'd0);
    chk("rst_state", DbgState, 2'd0);
    Reset_n = 1'b1;
    step();

    // Basic fetch: AddrValid driven after edge 0, sampled at edge 1
    wr(2'd2, 8'h3C);
    Addr = 2'd2; AddrValid = 1'b1; InstrReady = 1'b1;
    step();
    chk("basic_read_valid", InstrValid, 1'b0);
    chk("basic_read_busy", Busy, 1'b1);
    chk("basic_read_state", DbgState, 2'd1);
    AddrValid = 1'b0;
    step();
    chk("basic_valid", InstrValid, 1'b1);
    chk("basic_instr", Instr, 8'h3C);
    chk("basic_no_end", End, 1'b0);
    step();
    chk("basic_end", End, 1'b1);
    chk("basic_end_novalid", InstrValid, 1'b0);
    chk("basic_count", FetchCount, 8'd1);
    step();
    chk("basic_end_once", End, 1'b0);
    chk("basic_idle_busy", Busy, 1'b0);

    // Asynchronous reset mid-VALID
    wr(2'd3, 8'hA5);
    InstrReady = 1'b0; Addr = 2'd3; AddrValid = 1'b1;
    step();
    AddrValid = 1'b0;
    step();
    chk("rstv_pre_instr", Instr, 8'hA5);
    chk("rstv_pre_valid", InstrValid, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rstv_instr", Instr, 8'h00);
    chk("rstv_valid", InstrValid, 1'b0);
    chk("rstv_busy", Busy, 1'b0);
    chk("rstv_count", FetchCount, 8'd0);
    chk("rstv_end", End, 1'b0);
    #3 Reset_n = 1'b1;
    step();
    chk("rstv_after_end", End, 1'b0);

    // Back-pressure
    wr(2'd2, 8'h3C);
    Addr = 2'd2; AddrValid = 1'b1; InstrReady = 1'b0;
    step();
    AddrValid = 1'b0;
    step();
    chk("bp_instr", Instr, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      Addr = 2'(i); AddrValid = i[0];
      step();
      chk("bp_hold_instr", Instr, 8'h3C);
      chk("bp_hold_valid", InstrValid, 1'b1);
      chk("bp_hold_end", End, 1'b0);
    end
    AddrValid = 1'b0;
    InstrReady = 1'b1;
    step();
    chk("bp_end", End, 1'b1);
    chk("bp_count", FetchCount, 8'd1);
    step();
    chk("bp_end_once", End, 1'b0);

    // Read/write collision in READ
    wr(2'd1, 8'h11);
    Addr = 2'd1; AddrValid = 1'b1;
    step();
    AddrValid = 1'b0;
    WrEn = 1'b1; WrAddr = 2'd1; WrData = 8'h22;
    step();
    WrEn = 1'b0;
    chk("coll_old_word", Instr, 8'h11);
    step();
    step();
    Addr = 2'd1; AddrValid = 1'b1;
    step();
    AddrValid = 1'b0;
    step();
    chk("coll_new_word", Instr, 8'h22);
    step();
    chk("coll_count", FetchCount, 8'd3);
    step();

    // PC-driven sequence 0..3
    seq_exp[0] = 8'h10; seq_exp[1] = 8'h21; seq_exp[2] = 8'h32; seq_exp[3] = 8'h43;
    for (int i = 0; i < 4; i++) wr(2'(i), seq_exp[i]);
    Addr = 2'd0; AddrValid = 1'b1; InstrReady = 1'b1;
    ends = 0; words = 0; prev_end = 1'b0;
    for (int c = 0; c < 40 && ends < 4; c++) begin
      step();
      chk("seq_valid_end_excl", InstrValid & End, 1'b0);
      if (InstrValid) begin
        chk("seq_word", Instr, (words < 4) ? seq_exp[words] : 8'hXX);
        words++;
      end
      if (End) begin
        ends++;
        if (ends < 4) Addr = 2'(ends);
        else AddrValid = 1'b0;
      end
    end
    chk("seq_ends", ends, 4);
    chk("seq_words", words, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_stay_idle", DbgState, 2'd0);
    end
    chk("seq_count", FetchCount, 8'd7);

    // Saturation over 260 fetches
    Addr = 2'd0; AddrValid = 1'b1; InstrReady = 1'b1;
    ends = 0; prev_end = 1'b0;
    for (int c = 0; c < 1200 && ends < 260; c++) begin
      step();
      chk("sat_end_gap", End & prev_end, 1'b0);
      prev_end = End;
      if (End) ends++;
    end
    AddrValid = 1'b0;
    chk("sat_ends", ends, 260);
    chk("sat_count", FetchCount, 8'd255);
    step();
    step();
    chk("sat_idle_busy", Busy, 1'b0);
    chk("sat_count_hold", FetchCount, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
